// File: rtl/pipe_stage_reg_hs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_hs
// Brief    : STAGES-deep valid/ready pipeline register with optional skid
//            entries, synchronous flush and ctrl zeroing on bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg_hs #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int STAGES = 1,
    parameter int SKID   = 1,
    localparam int OCC_W = $clog2(2*STAGES+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    // Element k is the beat offered to stage k; element STAGES is the output.
    logic              w_v   [STAGES+1];
    logic [DATA_W-1:0] w_d   [STAGES+1];
    logic [CTRL_W-1:0] w_c   [STAGES+1];
    logic              w_rdy [STAGES+1];

    logic              w_in_fire;
    logic              w_out_fire;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    assign w_v[0]    = in_valid;
    assign w_d[0]    = in_data;
    assign w_c[0]    = in_ctrl;
    assign in_ready  = w_rdy[0];
    assign out_valid = w_v[STAGES];
    assign out_data  = w_d[STAGES];
    assign out_ctrl  = w_c[STAGES];
    assign occupancy = occ_q;

    generate
        if (SKID != 0) begin : g_skid
            assign w_rdy[STAGES] = out_ready;

            for (genvar k = 0; k < STAGES; k++) begin : g_stage
                logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
                logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
                logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
                logic              w_fire_in, w_fire_out;

                assign w_fire_in  = w_v[k] && !s_valid_q;
                assign w_fire_out = m_valid_q && w_rdy[k+1];

                always_comb begin
                    m_valid_d = m_valid_q;
                    m_data_d  = m_data_q;
                    m_ctrl_d  = m_ctrl_q;
                    s_valid_d = s_valid_q;
                    s_data_d  = s_data_q;
                    s_ctrl_d  = s_ctrl_q;
                    if (flush) begin
                        m_valid_d = 1'b0;
                        m_ctrl_d  = '0;
                        s_valid_d = 1'b0;
                        s_ctrl_d  = '0;
                    end else if (!m_valid_q || w_fire_out) begin
                        // Main slot frees up: skid has priority to keep order.
                        if (s_valid_q) begin
                            m_valid_d = 1'b1;
                            m_data_d  = s_data_q;
                            m_ctrl_d  = s_ctrl_q;
                            s_valid_d = 1'b0;
                            s_ctrl_d  = '0;
                        end else if (w_fire_in) begin
                            m_valid_d = 1'b1;
                            m_data_d  = w_d[k];
                            m_ctrl_d  = w_c[k];
                        end else begin
                            m_valid_d = 1'b0;
                            m_ctrl_d  = '0;
                        end
                    end else if (w_fire_in) begin
                        s_valid_d = 1'b1;
                        s_data_d  = w_d[k];
                        s_ctrl_d  = w_c[k];
                    end
                end

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        m_valid_q <= 1'b0;
                        m_data_q  <= '0;
                        m_ctrl_q  <= '0;
                        s_valid_q <= 1'b0;
                        s_data_q  <= '0;
                        s_ctrl_q  <= '0;
                    end else begin
                        m_valid_q <= m_valid_d;
                        m_data_q  <= m_data_d;
                        m_ctrl_q  <= m_ctrl_d;
                        s_valid_q <= s_valid_d;
                        s_data_q  <= s_data_d;
                        s_ctrl_q  <= s_ctrl_d;
                    end
                end

                assign w_rdy[k]   = !s_valid_q;
                assign w_v[k+1]   = m_valid_q;
                assign w_d[k+1]   = m_data_q;
                assign w_c[k+1]   = m_ctrl_q;
            end
        end else begin : g_stall
            logic w_en;
            assign w_en          = out_ready || !w_v[STAGES];
            assign w_rdy[STAGES] = w_en;

            for (genvar k = 0; k < STAGES; k++) begin : g_stage
                logic              valid_q, valid_d;
                logic [DATA_W-1:0] data_q, data_d;
                logic [CTRL_W-1:0] ctrl_q, ctrl_d;

                always_comb begin
                    valid_d = valid_q;
                    data_d  = data_q;
                    ctrl_d  = ctrl_q;
                    if (flush) begin
                        valid_d = 1'b0;
                        ctrl_d  = '0;
                    end else if (w_en) begin
                        // Bubbles shift too, but only real beats overwrite data.
                        valid_d = w_v[k];
                        if (w_v[k]) begin
                            data_d = w_d[k];
                            ctrl_d = w_c[k];
                        end else begin
                            ctrl_d = '0;
                        end
                    end
                end

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        valid_q <= 1'b0;
                        data_q  <= '0;
                        ctrl_q  <= '0;
                    end else begin
                        valid_q <= valid_d;
                        data_q  <= data_d;
                        ctrl_q  <= ctrl_d;
                    end
                end

                assign w_rdy[k]   = w_en;
                assign w_v[k+1]   = valid_q;
                assign w_d[k+1]   = data_q;
                assign w_c[k+1]   = ctrl_q;
            end
        end
    endgenerate

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (w_in_fire && !w_out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!w_in_fire && w_out_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg_hs
// Brief    : Directed self-checking bench over four pipe_stage_reg_hs configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg_hs;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        flush;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    // s1: STAGES=1 SKID=1, s2: STAGES=2 SKID=1, s3: STAGES=3 SKID=1, n2: STAGES=2 SKID=0
    logic s1_ir, s1_ov, s2_ir, s2_ov, s3_ir, s3_ov, n2_ir, n2_ov;
    logic [31:0] s1_od, s2_od, s3_od, n2_od;
    logic [7:0]  s1_oc, s2_oc, s3_oc, n2_oc;
    logic [1:0]  s1_occ;
    logic [2:0]  s2_occ, s3_occ, n2_occ;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic [7:0]  ic;
        logic        fl;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        logic [7:0]  oc;
        logic [1:0]  occ;
        logic        ir;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    pipe_stage_reg_hs #(.DATA_W(32), .CTRL_W(8), .STAGES(1), .SKID(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s1_ir),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(s1_ov),
        .out_ready(out_ready), .out_data(s1_od), .out_ctrl(s1_oc), .occupancy(s1_occ));

    pipe_stage_reg_hs #(.DATA_W(32), .CTRL_W(8), .STAGES(2), .SKID(1)) u_s2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s2_ir),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(s2_ov),
        .out_ready(out_ready), .out_data(s2_od), .out_ctrl(s2_oc), .occupancy(s2_occ));

    pipe_stage_reg_hs #(.DATA_W(32), .CTRL_W(8), .STAGES(3), .SKID(1)) u_s3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s3_ir),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(s3_ov),
        .out_ready(out_ready), .out_data(s3_od), .out_ctrl(s3_oc), .occupancy(s3_occ));

    pipe_stage_reg_hs #(.DATA_W(32), .CTRL_W(8), .STAGES(2), .SKID(0)) u_n2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n2_ir),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(n2_ov),
        .out_ready(out_ready), .out_data(n2_od), .out_ctrl(n2_oc), .occupancy(n2_occ));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] sb [$];
        logic [31:0] exp_d;
        logic [7:0]  or_pat;
        logic [7:0]  ir_pat;
        logic [31:0] next_d;
        logic        fin, fout;
        int          n_out;
        int          acc, emit;

        tbl[0]  = '{1'b1, 32'hA,  8'h11, 1'b0, 1'b0, 1'b1, 32'hA,  8'h11, 2'd1, 1'b1};
        tbl[1]  = '{1'b1, 32'hB,  8'h22, 1'b0, 1'b0, 1'b1, 32'hA,  8'h11, 2'd2, 1'b0};
        tbl[2]  = '{1'b1, 32'hC,  8'h33, 1'b0, 1'b0, 1'b1, 32'hA,  8'h11, 2'd2, 1'b0};
        tbl[3]  = '{1'b1, 32'hC,  8'h33, 1'b0, 1'b1, 1'b1, 32'hB,  8'h22, 2'd1, 1'b1};
        tbl[4]  = '{1'b1, 32'hC,  8'h33, 1'b0, 1'b1, 1'b1, 32'hC,  8'h33, 2'd1, 1'b1};
        tbl[5]  = '{1'b0, 32'hD,  8'hFF, 1'b0, 1'b1, 1'b0, 32'hC,  8'h00, 2'd0, 1'b1};
        tbl[6]  = '{1'b0, 32'hD,  8'hFF, 1'b0, 1'b1, 1'b0, 32'hC,  8'h00, 2'd0, 1'b1};
        tbl[7]  = '{1'b1, 32'h55, 8'h44, 1'b1, 1'b0, 1'b0, 32'hC,  8'h00, 2'd0, 1'b1};
        tbl[8]  = '{1'b1, 32'h66, 8'h01, 1'b0, 1'b0, 1'b1, 32'h66, 8'h01, 2'd1, 1'b1};
        tbl[9]  = '{1'b1, 32'h77, 8'h02, 1'b0, 1'b0, 1'b1, 32'h66, 8'h01, 2'd2, 1'b0};
        tbl[10] = '{1'b1, 32'h88, 8'h08, 1'b1, 1'b0, 1'b0, 32'h66, 8'h00, 2'd0, 1'b1};
        tbl[11] = '{1'b1, 32'h99, 8'h03, 1'b0, 1'b1, 1'b1, 32'h99, 8'h03, 2'd1, 1'b1};
        tbl[12] = '{1'b0, 32'h0,  8'h00, 1'b0, 1'b1, 1'b0, 32'h99, 8'h00, 2'd0, 1'b1};

        // Reset held with a live beat on the input.
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        in_ctrl   = 8'hFF;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_s3_ov", 32'(s3_ov), 32'd0);
        check("rst_hold_s3_ir", 32'(s3_ir), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_s1_ov", 32'(s1_ov), 32'd0);
        check("rst_s1_oc", 32'(s1_oc), 32'd0);
        check("rst_s1_od", s1_od, 32'd0);
        check("rst_s1_occ", 32'(s1_occ), 32'd0);
        check("rst_s1_ir", 32'(s1_ir), 32'd1);
        check("rst_s3_od", s3_od, 32'd0);
        check("rst_s3_occ", 32'(s3_occ), 32'd0);
        check("rst_n2_ov", 32'(n2_ov), 32'd0);
        check("rst_n2_od", n2_od, 32'd0);
        check("rst_n2_ir", 32'(n2_ir), 32'd1);
        check("rst_s2_oc", 32'(s2_oc), 32'd0);

        // Table-driven vectors on STAGES=1 SKID=1: backpressure, bubbles, flush.
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            in_ctrl   = tbl[i].ic;
            flush     = tbl[i].fl;
            out_ready = tbl[i].ordy;
            tick();
            check($sformatf("vec%0d_ov", i), 32'(s1_ov), 32'(tbl[i].ov));
            check($sformatf("vec%0d_od", i), s1_od, tbl[i].od);
            check($sformatf("vec%0d_oc", i), 32'(s1_oc), 32'(tbl[i].oc));
            check($sformatf("vec%0d_occ", i), 32'(s1_occ), 32'(tbl[i].occ));
            check($sformatf("vec%0d_ir", i), 32'(s1_ir), 32'(tbl[i].ir));
        end
        flush = 1'b0;

        // Streaming through STAGES=3 SKID=1, no backpressure.
        apply_reset();
        out_ready = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            in_valid = (e <= 10);
            in_data  = 32'(e);
            in_ctrl  = 8'(e);
            tick();
            acc  = (e < 10) ? e : 10;
            emit = (e - 3 < 0) ? 0 : ((e - 3 > 10) ? 10 : e - 3);
            check($sformatf("stream%0d_ov", e), 32'(s3_ov), 32'((e >= 3) && (e <= 12)));
            if ((e >= 3) && (e <= 12)) begin
                check($sformatf("stream%0d_od", e), s3_od, 32'(e - 2));
                check($sformatf("stream%0d_oc", e), 32'(s3_oc), 32'(e - 2));
            end else begin
                check($sformatf("stream%0d_oc", e), 32'(s3_oc), 32'd0);
            end
            check($sformatf("stream%0d_occ", e), 32'(s3_occ), 32'(acc - emit));
            check($sformatf("stream%0d_ir", e), 32'(s3_ir), 32'd1);
        end

        // Bubbles carrying an all-ones ctrl pattern.
        apply_reset();
        in_valid = 1'b0;
        in_data  = 32'h1234_5678;
        in_ctrl  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            out_ready = c[0];
            tick();
            check($sformatf("bub%0d_s3_ov", c), 32'(s3_ov), 32'd0);
            check($sformatf("bub%0d_s3_oc", c), 32'(s3_oc), 32'd0);
            check($sformatf("bub%0d_n2_ov", c), 32'(n2_ov), 32'd0);
            check($sformatf("bub%0d_n2_oc", c), 32'(n2_oc), 32'd0);
        end

        // Flush on STAGES=2 SKID=1 while full, with a colliding input beat.
        apply_reset();
        out_ready = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            in_valid = 1'b1;
            in_data  = 32'(b);
            in_ctrl  = 8'(b);
            tick();
        end
        check("fl_full_occ", 32'(s2_occ), 32'd4);
        check("fl_full_ir", 32'(s2_ir), 32'd0);
        check("fl_full_od", s2_od, 32'd1);
        in_valid = 1'b1;
        in_data  = 32'h55;
        in_ctrl  = 8'h55;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occ", 32'(s2_occ), 32'd0);
        check("fl_ov", 32'(s2_ov), 32'd0);
        check("fl_oc", 32'(s2_oc), 32'd0);
        check("fl_ir", 32'(s2_ir), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("fl_after%0d_ov", c), 32'(s2_ov), 32'd0);
            check($sformatf("fl_after%0d_od", c), s2_od, 32'd1);
        end

        // Global-enable mode STAGES=2 SKID=0 with toggling out_ready.
        apply_reset();
        or_pat = 8'b0101_0101;
        ir_pat = 8'b0101_0111;
        next_d = 32'h100;
        n_out  = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid  = (c < 8);
            in_data   = next_d;
            in_ctrl   = next_d[7:0];
            out_ready = (c < 8) ? or_pat[c] : 1'b1;
            #1;
            if (c < 8) check($sformatf("n2_ir%0d", c), 32'(n2_ir), 32'(ir_pat[c]));
            fin  = in_valid && n2_ir;
            fout = n2_ov && out_ready;
            if (fout) begin
                exp_d = (sb.size() > 0) ? sb.pop_front() : 32'hFFFF_FFFF;
                check($sformatf("n2_out%0d", n_out), n2_od, exp_d);
                check($sformatf("n2_ctl%0d", n_out), 32'(n2_oc), 32'(exp_d[7:0]));
                n_out++;
            end
            tick();
            if (fin) begin
                sb.push_back(next_d);
                next_d = next_d + 32'd1;
            end
        end
        check("n2_drained", 32'(sb.size()), 32'd0);
        check("n2_out_count", 32'(n_out), 32'd5);
        check("n2_occ_end", 32'(n2_occ), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
